// File: rtl/psram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : psram_arbiter
//  Description : Two-port burst arbiter in front of a PSRAM controller IP.
//                Grants one command at a time (round-robin on ties), streams
//                BURST_WORDS write beats from the granted port or forwards
//                BURST_WORDS read beats to it, and enforces a minimum spacing
//                of CMD_GAP cycles between cmd_en pulses.
//  Ports       : clk, rst                 - clock / sync active-high reset
//                init_calib               - PSRAM calibration done
//                pN_req_valid/we/addr     - port N command request (N=0,1)
//                pN_req_ready             - one-cycle accept pulse
//                pN_wdata/wmask/wdata_pop - FWFT write beat interface
//                pN_rdata/rdata_valid     - read beat return
//                cmd, cmd_en, addr        - command to PSRAM IP
//                wr_data, data_mask       - write beat to PSRAM IP
//                rd_data, rd_data_valid   - read beat from PSRAM IP
//                busy                     - high in any state but IDLE
//                rd_timeout_err           - sticky: read never answered
//                stray_rd_err             - sticky: unexpected read beat
//  Revision    : 1.0 - initial release
// ============================================================================
module psram_arbiter #(
    parameter int BURST_WORDS = 4,
    parameter int CMD_GAP     = 16,
    parameter int RD_TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init_calib,
    input  logic        p0_req_valid,
    input  logic        p0_req_we,
    input  logic [20:0] p0_req_addr,
    output logic        p0_req_ready,
    input  logic [63:0] p0_wdata,
    input  logic [7:0]  p0_wmask,
    output logic        p0_wdata_pop,
    output logic [63:0] p0_rdata,
    output logic        p0_rdata_valid,
    input  logic        p1_req_valid,
    input  logic        p1_req_we,
    input  logic [20:0] p1_req_addr,
    output logic        p1_req_ready,
    input  logic [63:0] p1_wdata,
    input  logic [7:0]  p1_wmask,
    output logic        p1_wdata_pop,
    output logic [63:0] p1_rdata,
    output logic        p1_rdata_valid,
    output logic        cmd,
    output logic        cmd_en,
    output logic [20:0] addr,
    output logic [63:0] wr_data,
    output logic [7:0]  data_mask,
    input  logic [63:0] rd_data,
    input  logic        rd_data_valid,
    output logic        busy,
    output logic        rd_timeout_err,
    output logic        stray_rd_err
);

    localparam int c_BEAT_W = $clog2(BURST_WORDS) + 1;
    localparam int c_GAP_W  = $clog2(CMD_GAP) + 1;
    localparam int c_TMO_W  = $clog2(RD_TIMEOUT) + 1;

    localparam logic [c_BEAT_W-1:0] c_BEAT_ONE  = c_BEAT_W'(1);
    localparam logic [c_BEAT_W-1:0] c_BEAT_LAST = c_BEAT_W'(BURST_WORDS - 1);
    localparam logic [c_GAP_W-1:0]  c_GAP_ONE   = c_GAP_W'(1);
    localparam logic [c_GAP_W-1:0]  c_GAP_LAST  = c_GAP_W'(CMD_GAP - 1);
    localparam logic [c_GAP_W-1:0]  c_GAP_FIRST = (CMD_GAP > 1) ? c_GAP_ONE : '0;
    localparam logic [c_TMO_W-1:0]  c_TMO_ONE   = c_TMO_W'(1);
    localparam logic [c_TMO_W-1:0]  c_TMO_LAST  = c_TMO_W'(RD_TIMEOUT - 1);

    localparam logic [2:0] S_WAIT_CALIB = 3'd0;
    localparam logic [2:0] S_IDLE       = 3'd1;
    localparam logic [2:0] S_WR_BURST   = 3'd2;
    localparam logic [2:0] S_RD_WAIT    = 3'd3;
    localparam logic [2:0] S_RD_BURST   = 3'd4;
    localparam logic [2:0] S_GAP        = 3'd5;

    logic [2:0]          r_state;
    logic [2:0]          w_state_nxt;
    logic                r_last_grant;
    logic                r_gnt;
    logic [c_BEAT_W-1:0] r_beat;
    logic [c_GAP_W-1:0]  r_gap;
    logic [c_TMO_W-1:0]  r_tmo;
    logic                r_tmo_err;
    logic                r_stray_err;

    logic                w_pick;
    logic                w_grant;
    logic                w_fwd;
    logic                w_timeout;
    logic                w_stray;
    logic                w_sel_we;
    logic [20:0]         w_sel_addr;
    logic [63:0]         w_gnt_wdata;
    logic [7:0]          w_gnt_wmask;
    logic [2:0]          w_after_burst;

    // Tie goes to the port that did not win last time.
    assign w_pick      = (p0_req_valid && p1_req_valid) ? ~r_last_grant : p1_req_valid;
    assign w_sel_we    = w_pick ? p1_req_we   : p0_req_we;
    assign w_sel_addr  = w_pick ? p1_req_addr : p0_req_addr;
    assign w_gnt_wdata = r_gnt  ? p1_wdata    : p0_wdata;
    assign w_gnt_wmask = r_gnt  ? p1_wmask    : p0_wmask;

    // r_gap holds the number of cycles since cmd_en (saturating), so when it
    // reads CMD_GAP-1 this cycle the next cycle may already issue a command.
    assign w_after_burst = (r_gap == c_GAP_LAST) ? S_IDLE : S_GAP;

    assign w_stray = rd_data_valid && (r_state != S_RD_WAIT) && (r_state != S_RD_BURST);

    always_comb begin
        w_state_nxt  = r_state;
        w_grant      = 1'b0;
        w_fwd        = 1'b0;
        w_timeout    = 1'b0;
        cmd_en       = 1'b0;
        cmd          = 1'b0;
        addr         = '0;
        wr_data      = '0;
        data_mask    = '0;
        p0_req_ready = 1'b0;
        p1_req_ready = 1'b0;
        p0_wdata_pop = 1'b0;
        p1_wdata_pop = 1'b0;
        case (r_state)
            S_WAIT_CALIB: begin
                if (init_calib) w_state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (!init_calib) begin
                    w_state_nxt = S_WAIT_CALIB;
                end else if (p0_req_valid || p1_req_valid) begin
                    w_grant      = 1'b1;
                    cmd_en       = 1'b1;
                    cmd          = w_sel_we;
                    addr         = w_sel_addr;
                    p0_req_ready = ~w_pick;
                    p1_req_ready = w_pick;
                    if (w_sel_we) begin
                        // First beat goes out alongside the command.
                        wr_data      = w_pick ? p1_wdata : p0_wdata;
                        data_mask    = w_pick ? p1_wmask : p0_wmask;
                        p0_wdata_pop = ~w_pick;
                        p1_wdata_pop = w_pick;
                        w_state_nxt  = (BURST_WORDS == 1) ? S_GAP : S_WR_BURST;
                    end else begin
                        w_state_nxt  = S_RD_WAIT;
                    end
                end
            end
            S_WR_BURST: begin
                wr_data      = w_gnt_wdata;
                data_mask    = w_gnt_wmask;
                p0_wdata_pop = ~r_gnt;
                p1_wdata_pop = r_gnt;
                if (r_beat == c_BEAT_LAST) w_state_nxt = w_after_burst;
            end
            S_RD_WAIT: begin
                if (rd_data_valid) begin
                    w_fwd       = 1'b1;
                    w_state_nxt = (BURST_WORDS == 1) ? w_after_burst : S_RD_BURST;
                end else if (r_tmo == c_TMO_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_GAP;
                end
            end
            S_RD_BURST: begin
                if (rd_data_valid) begin
                    w_fwd = 1'b1;
                    if (r_beat == c_BEAT_LAST) w_state_nxt = w_after_burst;
                end
            end
            S_GAP: begin
                if (r_gap == c_GAP_LAST) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_WAIT_CALIB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_WAIT_CALIB;
            r_last_grant <= 1'b1;
            r_gnt        <= 1'b0;
            r_beat       <= '0;
            r_gap        <= '0;
            r_tmo        <= '0;
            r_tmo_err    <= 1'b0;
            r_stray_err  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_tmo_err   <= r_tmo_err | w_timeout;
            r_stray_err <= r_stray_err | w_stray;
            if (w_grant) begin
                r_gnt        <= w_pick;
                r_last_grant <= w_pick;
                // Writes have already moved one beat in the grant cycle.
                r_beat       <= w_sel_we ? c_BEAT_ONE : '0;
                r_gap        <= c_GAP_FIRST;
                r_tmo        <= c_TMO_ONE;
            end else begin
                if (r_gap != c_GAP_LAST) r_gap <= r_gap + c_GAP_ONE;
                if ((r_state == S_WR_BURST) || w_fwd) r_beat <= r_beat + c_BEAT_ONE;
                if ((r_state == S_RD_WAIT) && (r_tmo != c_TMO_LAST)) r_tmo <= r_tmo + c_TMO_ONE;
            end
        end
    end

    assign p0_rdata_valid = w_fwd & ~r_gnt;
    assign p1_rdata_valid = w_fwd &  r_gnt;
    assign p0_rdata       = p0_rdata_valid ? rd_data : '0;
    assign p1_rdata       = p1_rdata_valid ? rd_data : '0;
    assign busy           = (r_state != S_IDLE);
    assign rd_timeout_err = r_tmo_err;
    assign stray_rd_err   = r_stray_err;

endmodule
`default_nettype wire

// File: tb/tb_psram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_psram_arbiter
//  Description : Directed self-checking bench for psram_arbiter: calibration
//                hold-off, write burst, read burst, round-robin spacing, read
//                timeout, mid-burst reset, calibration loss and stray beats.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_psram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        init_calib = 1'b0;
    logic        p0_req_valid = 1'b0, p0_req_we = 1'b0;
    logic [20:0] p0_req_addr = '0;
    logic        p0_req_ready, p0_wdata_pop, p0_rdata_valid;
    logic [63:0] p0_wdata = '0, p0_rdata;
    logic [7:0]  p0_wmask = '0;
    logic        p1_req_valid = 1'b0, p1_req_we = 1'b0;
    logic [20:0] p1_req_addr = '0;
    logic        p1_req_ready, p1_wdata_pop, p1_rdata_valid;
    logic [63:0] p1_wdata = '0, p1_rdata;
    logic [7:0]  p1_wmask = '0;
    logic        cmd, cmd_en, busy, rd_timeout_err, stray_rd_err;
    logic [20:0] addr;
    logic [63:0] wr_data;
    logic [7:0]  data_mask;
    logic [63:0] rd_data = '0;
    logic        rd_data_valid = 1'b0;

    psram_arbiter #(.BURST_WORDS(4), .CMD_GAP(16), .RD_TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .init_calib(init_calib),
        .p0_req_valid(p0_req_valid), .p0_req_we(p0_req_we), .p0_req_addr(p0_req_addr),
        .p0_req_ready(p0_req_ready), .p0_wdata(p0_wdata), .p0_wmask(p0_wmask),
        .p0_wdata_pop(p0_wdata_pop), .p0_rdata(p0_rdata), .p0_rdata_valid(p0_rdata_valid),
        .p1_req_valid(p1_req_valid), .p1_req_we(p1_req_we), .p1_req_addr(p1_req_addr),
        .p1_req_ready(p1_req_ready), .p1_wdata(p1_wdata), .p1_wmask(p1_wmask),
        .p1_wdata_pop(p1_wdata_pop), .p1_rdata(p1_rdata), .p1_rdata_valid(p1_rdata_valid),
        .cmd(cmd), .cmd_en(cmd_en), .addr(addr), .wr_data(wr_data), .data_mask(data_mask),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid), .busy(busy),
        .rd_timeout_err(rd_timeout_err), .stray_rd_err(stray_rd_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Returns the cycle number of the first non-busy cycle, or -1 on expiry.
    task automatic wait_idle(input int lim, output int t);
        t = -1;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk); #1;
            if (!busy) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) check("wait_idle_expired", 64'd0, 64'd1);
    endtask

    logic [63:0] beats   [0:3];
    logic [7:0]  masks   [0:3];
    logic [63:0] rbeats  [0:3];
    int          gport   [0:3];
    int          gtime   [0:3];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t_grant, t_idle, widx, seen_cmd, seen_idle, ng, n_early;

        beats[0]  = 64'h01234567DEADBEEF; beats[1]  = 64'h89ABCDEF00C0FFEE;
        beats[2]  = 64'hFEDCBA9876543210; beats[3]  = 64'h0F1E2D3C4B5A6978;
        masks[0]  = 8'h01; masks[1] = 8'h3C; masks[2] = 8'hFF; masks[3] = 8'h80;
        rbeats[0] = 64'hA5A5A5A500000001; rbeats[1] = 64'h5A5A5A5A00000002;
        rbeats[2] = 64'hCAFEF00D00000003; rbeats[3] = 64'h1234432100000004;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", busy, 1);
        check("rst_cmd_en", cmd_en, 0);
        check("rst_errs", {rd_timeout_err, stray_rd_err}, 0);
        @(negedge clk);
        rst = 1'b0;

        // ---------------- calibration hold-off ----------------
        p0_req_valid = 1'b1; p0_req_we = 1'b1; p0_req_addr = 21'h20;
        p0_wdata = beats[0]; p0_wmask = masks[0];
        seen_cmd = 0; seen_idle = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (cmd_en || p0_req_ready) seen_cmd++;
            if (!busy) seen_idle++;
        end
        check("calib_no_cmd", seen_cmd, 0);
        check("calib_busy_low_cycles", seen_idle, 0);
        @(negedge clk);
        init_calib = 1'b1;
        #1;
        check("calib_same_cycle_cmd", cmd_en, 0);

        // ---------------- p0 write burst ----------------
        widx = 0; t_grant = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 1) p0_req_valid = 1'b0;
            p0_wdata = beats[widx]; p0_wmask = masks[widx];
            #1;
            if (c == 0) begin
                check("wr_grant", {cmd_en, cmd, p0_req_ready, p1_req_ready}, 4'b1110);
                check("wr_addr", addr, 21'h20);
                t_grant = cyc;
            end else begin
                check("wr_cmd_en_low", cmd_en, 0);
            end
            if (c < 4) begin
                check("wr_pop", {p0_wdata_pop, p1_wdata_pop}, 2'b10);
                check("wr_data", wr_data, beats[c]);
                check("wr_mask", data_mask, masks[c]);
            end else begin
                check("wr_done_pop", {p0_wdata_pop, wr_data, data_mask}, 0);
            end
            if (p0_wdata_pop && widx < 3) widx++;
        end
        wait_idle(40, t_idle);
        check("wr_gap_to_idle", t_idle - t_grant, 16);

        // ---------------- p1 read burst ----------------
        p1_req_valid = 1'b1; p1_req_we = 1'b0; p1_req_addr = 21'h155;
        #1;
        check("rd_grant", {cmd_en, cmd, p0_req_ready, p1_req_ready}, 4'b1001);
        check("rd_addr", addr, 21'h155);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            p1_req_valid  = 1'b0;
            rd_data_valid = (k >= 12 && k <= 15);
            rd_data       = rd_data_valid ? rbeats[(k - 12) & 3] : 64'hBAD0BAD0BAD0BAD0;
            #1;
            check("rd_p1_valid", p1_rdata_valid, (k >= 12 && k <= 15));
            check("rd_p0_valid", p0_rdata_valid, 0);
            if (k >= 12 && k <= 15) check("rd_p1_data", p1_rdata, rbeats[k - 12]);
            if (k == 16) check("rd_idle_after_burst", busy, 0);
        end
        rd_data_valid = 1'b0;

        // ---------------- round-robin with both ports requesting ----------------
        p0_req_valid = 1'b1; p0_req_we = 1'b1; p0_req_addr = 21'h100;
        p1_req_valid = 1'b1; p1_req_we = 1'b1; p1_req_addr = 21'h200;
        ng = 0;
        for (int i = 0; i < 100 && ng < 4; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            if (cmd_en) begin
                gport[ng] = p1_req_ready ? 1 : 0;
                gtime[ng] = cyc;
                check("rr_one_ready", p0_req_ready ^ p1_req_ready, 1);
                ng++;
            end
        end
        check("rr_grant_count", ng, 4);
        for (int g = 0; g < 4; g++) begin
            check("rr_port", gport[g], g & 1);
            if (g > 0) check("rr_spacing", gtime[g] - gtime[g - 1], 16);
        end
        @(negedge clk);
        p0_req_valid = 1'b0; p1_req_valid = 1'b0;
        wait_idle(40, t_idle);

        // ---------------- read timeout, then mid-burst reset ----------------
        p0_req_valid = 1'b1; p0_req_we = 1'b0; p0_req_addr = 21'h3;
        #1;
        check("to_grant", {cmd_en, cmd, p0_req_ready}, 3'b101);
        t_grant = cyc; n_early = 0;
        for (int k = 1; k <= 68; k++) begin
            @(negedge clk);
            p0_req_valid = 1'b0;
            if (k == 1) begin
                p1_req_valid = 1'b1; p1_req_we = 1'b1; p1_req_addr = 21'h1ABCD;
            end
            if (k == 66) p1_req_valid = 1'b0;
            if (k == 67) rst = 1'b1;
            p1_wdata = beats[k & 3]; p1_wmask = masks[k & 3];
            #1;
            if (k < 65 && cmd_en) n_early++;
            if (k == 63) check("to_flag_before", rd_timeout_err, 0);
            if (k == 64) check("to_flag_set", rd_timeout_err, 1);
            if (k == 65) begin
                check("to_next_grant", {cmd_en, cmd, p1_req_ready}, 3'b111);
                check("to_next_addr", addr, 21'h1ABCD);
                check("to_next_delay", cyc - t_grant, 65);
            end
            if (k == 67) check("rst_beat2_pop", p1_wdata_pop, 1);
            if (k == 68) begin
                check("rst_ctrl_outs", {cmd_en, cmd, p0_req_ready, p1_req_ready,
                                        p0_wdata_pop, p1_wdata_pop,
                                        p0_rdata_valid, p1_rdata_valid}, 0);
                check("rst_addr", addr, 0);
                check("rst_wr_data", {wr_data, data_mask}, 0);
                check("rst_errs_cleared", {rd_timeout_err, stray_rd_err}, 0);
                check("rst_wait_calib", busy, 1);
            end
        end
        check("to_no_early_cmd", n_early, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_no_resume", {busy, p1_wdata_pop, cmd_en}, 0);

        // ---------------- calibration loss in IDLE ----------------
        @(negedge clk);
        init_calib = 1'b0;
        p0_req_valid = 1'b1; p0_req_we = 1'b1; p0_req_addr = 21'h7;
        #1;
        check("calib_loss_no_grant", {cmd_en, p0_req_ready}, 0);
        @(negedge clk);
        p0_req_valid = 1'b0;
        #1;
        check("calib_loss_busy", busy, 1);
        init_calib = 1'b1;
        @(negedge clk); #1;
        check("calib_back_idle", busy, 0);

        // ---------------- stray read beat in IDLE ----------------
        rd_data_valid = 1'b1; rd_data = 64'hDEAD_0000_BEEF_0000;
        #1;
        check("stray_not_fwd", {p0_rdata_valid, p1_rdata_valid}, 0);
        check("stray_flag_before", stray_rd_err, 0);
        @(negedge clk);
        rd_data_valid = 1'b0;
        #1;
        check("stray_flag_set", stray_rd_err, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
